// File: rtl/mau_operand_stager_pkg.sv
// Shared constants and types for the MAU operand stager: register map, CTRL bits,
// FSM state encoding and default parameters.
package mau_operand_stager_pkg;

    localparam logic [2:0] ADDR_A_LO = 3'd0;
    localparam logic [2:0] ADDR_A_HI = 3'd1;
    localparam logic [2:0] ADDR_B_LO = 3'd2;
    localparam logic [2:0] ADDR_B_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL = 3'd4;

    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;

    localparam int unsigned DEFAULT_WORK_CYCLES = 6;
    localparam logic [23:0] DEFAULT_Q           = 24'd8380417;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    // Single conditional subtraction: maps [0, 2q) onto [0, q).
    function automatic logic [23:0] reduce_mod(input logic [23:0] x, input logic [23:0] q);
        return (x >= q) ? (x - q) : x;
    endfunction

endpackage

// File: rtl/mau_pair_fifo.sv
// Synchronous Depth x Width FIFO with flush; push while full succeeds only with a
// simultaneous pop. Read data is the current head (fall-through).
module mau_pair_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
            else if (!push_ok && pop_ok) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mau_operand_stager.sv
// Stages 24-bit operand pairs from 16-bit bus writes, queues them and plays them to the
// MAU in bursts. Optional MAU_OPERAND_REDUCE_EN reduces operands mod Q at push time.
module mau_operand_stager
    import mau_operand_stager_pkg::*;
#(
    parameter int unsigned Depth      = 4,
    parameter int unsigned WorkCycles = DEFAULT_WORK_CYCLES,
    parameter logic [23:0] Q          = DEFAULT_Q
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [2:0]             wr_addr_i,
    input  logic [15:0]            wr_data_i,
    input  logic                   start_i,
    output logic [23:0]            a_out_o,
    output logic [23:0]            b_out_o,
    output logic                   mau_en_o,
    output logic                   trig_n_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [$clog2(Depth):0] fifo_cnt_o,
    output logic                   ovf_o
);
    localparam int unsigned CntW = (WorkCycles > 1) ? $clog2(WorkCycles) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WorkCycles - 1);

    logic [23:0] a_stage_q, a_stage_d, b_stage_q, b_stage_d;
    logic [23:0] a_push, b_push, a_out_q, b_out_q;
    logic [47:0] fifo_rdata;
    logic        push, pop, flush, clr_ovf, ctrl_wr, fifo_full, fifo_empty;
    logic        ovf_q, ovf_d, mau_en_q, trig_n_q, busy_q, done_q;
    logic [CntW-1:0] cnt_q;
    state_e      state_q;

    always_comb begin
        a_stage_d = a_stage_q;
        b_stage_d = b_stage_q;
        if (wr_en_i) begin
            case (wr_addr_i)
                ADDR_A_LO: a_stage_d[15:0]  = wr_data_i;
                ADDR_A_HI: a_stage_d[23:16] = wr_data_i[7:0];
                ADDR_B_LO: b_stage_d[15:0]  = wr_data_i;
                ADDR_B_HI: b_stage_d[23:16] = wr_data_i[7:0];
                default:   ;
            endcase
        end
    end

    assign push    = wr_en_i && (wr_addr_i == ADDR_B_HI);
    assign ctrl_wr = wr_en_i && (wr_addr_i == ADDR_CTRL);
    assign flush   = ctrl_wr && wr_data_i[CTRL_FLUSH_BIT] && (state_q == StIdle);
    assign clr_ovf = ctrl_wr && wr_data_i[CTRL_CLR_OVF_BIT];
    assign pop     = (state_q == StLoad);

`ifdef MAU_OPERAND_REDUCE_EN
    assign a_push = reduce_mod(a_stage_q, Q);
    assign b_push = reduce_mod({wr_data_i[7:0], b_stage_q[15:0]}, Q);
`else
    logic unused_q;
    assign unused_q = ^Q;
    assign a_push   = a_stage_q;
    assign b_push   = {wr_data_i[7:0], b_stage_q[15:0]};
`endif

    // A dropped push sets ovf even if a clear arrives in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_stage_q <= '0;
            b_stage_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            a_stage_q <= a_stage_d;
            b_stage_q <= b_stage_d;
            ovf_q     <= ovf_d;
        end
    end

    mau_pair_fifo #(
        .Depth (Depth),
        .Width (48)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i ({a_push, b_push}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_out_q  <= '0;
            b_out_q  <= '0;
            mau_en_q <= 1'b0;
            trig_n_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i && !fifo_empty) begin
                        state_q  <= StLoad;
                        trig_n_q <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                StLoad: begin
                    a_out_q  <= fifo_rdata[47:24];
                    b_out_q  <= fifo_rdata[23:0];
                    cnt_q    <= '0;
                    mau_en_q <= 1'b1;
                    trig_n_q <= 1'b1;
                    state_q  <= StRun;
                end
                StRun: begin
                    if (cnt_q == LastCnt) begin
                        mau_en_q <= 1'b0;
                        if (!fifo_empty) begin
                            state_q <= StLoad;
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_out_o  = a_out_q;
    assign b_out_o  = b_out_q;
    assign mau_en_o = mau_en_q;
    assign trig_n_o = trig_n_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign ovf_o    = ovf_q;

endmodule
